lynx_tape_player: RTL



---
 rtl/lynx_tape_player.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lynx_tape_player.sv
// Cassette playback source: buffers host tape bytes in a small FIFO and replays
// them as a Lynx frequency-encoded square wave (leader, sync byte, data MSB first).
module lynx_tape_player #(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned T0_HALF     = 1000,
    parameter int unsigned T1_HALF     = 500,
    parameter int unsigned LEADER_BITS = 768,
    parameter logic [7:0]  SYNC        = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       play,
    input  logic       motor,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       eof,
    output logic       ear,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned HMAX  = (T0_HALF > T1_HALF) ? T0_HALF : T1_HALF;
    localparam int unsigned CW    = $clog2(HMAX + 1);
    localparam int unsigned LB_W  = $clog2(LEADER_BITS + 1);
    localparam int unsigned BW    = (LB_W > 4) ? LB_W : 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEADER = 3'd1;
    localparam logic [2:0] S_SYNC   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STALL  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    shift_q, shift_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_q, half_d;
    logic          active_q, active_d;
    logic          ear_q, ear_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic          din_ready_q, din_ready_d;
    logic [7:0]    mem_q [DEPTH];

    logic          tick;
    logic          wr_en;
    logic          empty;
    logic [7:0]    fifo_rd;
    logic          pop;
    logic          flush;
    logic          start_bit;
    logic          start_val;

    assign tick    = ce && motor;
    assign wr_en   = din_valid && din_ready_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_rd = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign din_ready = din_ready_q;
    assign ear       = ear_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
        end
    end

    // Next-state, bit timing and FIFO pointer logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        active_d   = active_q;
        ear_d      = ear_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        flush      = 1'b0;
        start_bit  = 1'b0;
        start_val  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ear_d = 1'b0;
                if (tick && play && !empty) begin
                    state_d    = S_LEADER;
                    bitcnt_d   = BW'(LEADER_BITS);
                    shift_d    = 8'h00;
                    active_d   = 1'b0;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                end
            end
            S_LEADER, S_SYNC, S_DATA: begin
                if (tick) begin
                    if (!active_q) begin
                        start_bit = 1'b1;
                        start_val = shift_q[7];
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (ear_q) begin
                        ear_d = 1'b0;
                        cnt_d = half_q - CW'(1);
                    end else if (bitcnt_q != BW'(1)) begin
                        bitcnt_d  = bitcnt_q - BW'(1);
                        shift_d   = {shift_q[6:0], 1'b0};
                        start_bit = 1'b1;
                        start_val = shift_q[6];
                    end else if (state_q == S_LEADER) begin
                        state_d   = S_SYNC;
                        shift_d   = SYNC;
                        bitcnt_d  = BW'(8);
                        start_bit = 1'b1;
                        start_val = SYNC[7];
                    end else if (!empty) begin
                        // byte boundary: next byte starts on this same tick
                        pop       = 1'b1;
                        state_d   = S_DATA;
                        shift_d   = fifo_rd;
                        bitcnt_d  = BW'(8);
                        start_bit = 1'b1;
                        start_val = fifo_rd[7];
                    end else if (eof) begin
                        state_d  = S_DONE;
                        active_d = 1'b0;
                    end else begin
                        state_d    = S_STALL;
                        active_d   = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
            S_STALL: begin
                ear_d = 1'b0;
                if (tick) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_d  = S_DATA;
                        shift_d  = fifo_rd;
                        bitcnt_d = BW'(8);
                        active_d = 1'b0;
                    end else if (eof) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ear_d = 1'b0;
                if (!play) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ear_d   = 1'b0;
            end
        endcase

        if (start_bit) begin
            active_d = 1'b1;
            ear_d    = 1'b1;
            half_d   = start_val ? CW'(T1_HALF) : CW'(T0_HALF);
            cnt_d    = start_val ? CW'(T1_HALF - 1) : CW'(T0_HALF - 1);
        end

        // Host abort: return to IDLE and discard whatever is still queued
        if (!play && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_IDLE;
            flush    = 1'b1;
            active_d = 1'b0;
            ear_d    = 1'b0;
        end

        wr_ptr_d    = wr_ptr_q + PW'(wr_en);
        rd_ptr_d    = flush ? wr_ptr_q : (rd_ptr_q + PW'(pop));
        din_ready_d = ((wr_ptr_d - rd_ptr_d) != PW'(DEPTH));
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            cnt_q       <= '0;
            half_q      <= '0;
            active_q    <= 1'b0;
            ear_q       <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            din_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            active_q    <= active_d;
            ear_q       <= ear_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            din_ready_q <= din_ready_d;
        end
    end

endmodule
